// File: rtl/fifo_burst_drain.sv
// Drains a first-word-fall-through FIFO into framed valid/ready bursts with first/last markers.
// Optional completed-burst counter built only when FIFO_BURST_DRAIN_STATS_EN is defined.
module fifo_burst_drain #(
  parameter int unsigned data_wd   = 32,
  parameter int unsigned max_burst = 8,
  parameter int unsigned bc_wd     = 3,
  parameter int unsigned timeout   = 16,
  parameter int unsigned to_wd     = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fifo_empty,
  input  logic [data_wd-1:0] i_fifo_rd_data,
  output logic               o_fifo_rd,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [data_wd-1:0] o_out_data,
  output logic               o_out_first,
  output logic               o_out_last,
  output logic               o_busy,
  output logic [15:0]        o_burst_cnt
);

  localparam logic [bc_wd-1:0] LastIdx = bc_wd'(max_burst - 1);
  localparam logic [to_wd-1:0] ToMax   = to_wd'(timeout);

  logic               r_p_valid;
  logic [data_wd-1:0] r_p_data;
  logic               r_out_valid;
  logic [data_wd-1:0] r_out_data;
  logic               r_out_first;
  logic               r_out_last;
  logic [bc_wd-1:0]   r_beat;
  logic [to_wd-1:0]   r_to_cnt;
  logic               r_sob;

  logic w_o_free;
  logic w_idx_last;
  logic w_to_hit;
  logic w_decided;
  logic w_last;
  logic w_move;
  logic w_pop;

  // A pending word is released once its last-ness is known: burst full, more data behind it, or timed out.
  assign w_o_free   = !r_out_valid || i_out_ready;
  assign w_idx_last = (r_beat == LastIdx);
  assign w_to_hit   = (r_to_cnt == ToMax);
  assign w_decided  = w_idx_last || !i_fifo_empty || w_to_hit;
  assign w_last     = w_idx_last || (i_fifo_empty && w_to_hit);
  assign w_move     = r_p_valid && w_o_free && w_decided;
  assign w_pop      = !i_fifo_empty && (!r_p_valid || w_move);

  assign o_fifo_rd   = w_pop;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_first = r_out_first;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_p_valid || r_out_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_valid   <= 1'b0;
      r_p_data    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_beat      <= '0;
      r_to_cnt    <= '0;
      r_sob       <= 1'b1;
    end else begin
      if (w_pop) begin
        r_p_valid <= 1'b1;
        r_p_data  <= i_fifo_rd_data;
      end else if (w_move) begin
        r_p_valid <= 1'b0;
      end

      if (w_move) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_p_data;
        r_out_first <= r_sob;
        r_out_last  <= w_last;
        if (w_last) begin
          r_beat <= '0;
          r_sob  <= 1'b1;
        end else begin
          r_beat <= r_beat + bc_wd'(1);
          r_sob  <= 1'b0;
        end
      end else if (w_o_free) begin
        r_out_valid <= 1'b0;
      end

      // Idle timer only runs while a word waits on an empty FIFO with nothing else deciding it.
      if (w_pop || w_move) begin
        r_to_cnt <= '0;
      end else if (r_p_valid && i_fifo_empty && !w_decided) begin
        r_to_cnt <= r_to_cnt + to_wd'(1);
      end
    end
  end

`ifdef FIFO_BURST_DRAIN_STATS_EN
  logic [15:0] r_burst_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_burst_cnt <= '0;
    end else if (r_out_valid && i_out_ready && r_out_last) begin
      r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

  assign o_burst_cnt = r_burst_cnt;
`else
  assign o_burst_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: queue-based FIFO model, cluster-chunking scoreboard, table and directed cases.
module tb_fifo_burst_drain;

  localparam int unsigned DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_fifo_empty = 1'b1;
  logic [DW-1:0] i_fifo_rd_data = '0;
  logic          o_fifo_rd;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [DW-1:0] o_out_data;
  logic          o_out_first;
  logic          o_out_last;
  logic          o_busy;
  logic [15:0]   o_burst_cnt;

  fifo_burst_drain dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_rd_data (i_fifo_rd_data),
    .o_fifo_rd      (o_fifo_rd),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_data     (o_out_data),
    .o_out_first    (o_out_first),
    .o_out_last     (o_out_last),
    .o_busy         (o_busy),
    .o_burst_cnt    (o_burst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } beat_t;

  typedef struct {
    int n_words;
    int exp_lat;
    int exp_bursts;
  } vec_t;

  logic [DW-1:0] fifo_q[$];
  beat_t         exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            bursts = 0;
  int            pops = 0;
  int            ready_mode = 0;
  logic          pop_s = 1'b0;
  logic          p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1, p_first = 1'b0, p_last = 1'b0;
  logic [DW-1:0] p_data = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void upd();
    i_fifo_empty   = (fifo_q.size() == 0);
    i_fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endfunction

  function automatic void push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    upd();
  endfunction

  // Behavioural model: a contiguous cluster splits into max-burst chunks, the cluster tail closing the last one.
  function automatic void push_cluster(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      push_word(w);
      exp_q.push_back('{w, (i % MB) == 0, ((i % MB) == MB - 1) || (i == n - 1)});
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((fifo_q.size() != 0 || o_busy || exp_q.size() != 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("drain_timeout", n, -1);
  endtask

  // FIFO model: pop on the edge where the DUT strobed read, then refresh head/empty.
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_s) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    upd();
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       i_out_ready = 1'b0;
      1:       i_out_ready = 1'b1;
      default: i_out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Monitor: read-while-empty, hold-under-backpressure and accepted-beat scoreboard.
  always @(negedge clk) begin
    beat_t e;
    pop_s = o_fifo_rd;
    if (o_fifo_rd) chk("rd_when_empty", longint'(i_fifo_empty), 0);
    if (!p_rst && !i_rst && p_valid && !p_ready) begin
      chk("hold_valid", longint'(o_out_valid), 1);
      chk("hold_data", longint'({o_out_first, o_out_last, o_out_data}),
          longint'({p_first, p_last, p_data}));
    end
    if (o_out_valid && i_out_ready && !i_rst) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", longint'(o_out_data), -1);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", longint'(o_out_data), longint'(e.d));
        chk("beat_first", longint'(o_out_first), longint'(e.f));
        chk("beat_last", longint'(o_out_last), longint'(e.l));
      end
      if (o_out_last) bursts++;
    end
    p_valid = o_out_valid;
    p_ready = i_out_ready;
    p_rst   = i_rst;
    p_first = o_out_first;
    p_last  = o_out_last;
    p_data  = o_out_data;
  end

  function automatic longint exp_cnt();
`ifdef FIFO_BURST_DRAIN_STATS_EN
    return longint'(bursts & 16'hFFFF);
`else
    return 0;
`endif
  endfunction

  initial begin
    vec_t        vecs[7];
    int          lat;
    int          b0;
    int          p0;
    logic [DW-1:0] w2;

    vecs[0] = '{10, 2, 2};
    vecs[1] = '{1, 18, 1};
    vecs[2] = '{8, 2, 1};
    vecs[3] = '{9, 2, 2};
    vecs[4] = '{16, 2, 2};
    vecs[5] = '{17, 2, 3};
    vecs[6] = '{2, 2, 1};

    upd();
    repeat (3) step();
    i_rst = 1'b0;
    chk("rst_valid", longint'(o_out_valid), 0);
    chk("rst_first_last", longint'({o_out_first, o_out_last}), 0);
    chk("rst_data", longint'(o_out_data), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_burst_cnt", longint'(o_burst_cnt), 0);
    chk("rst_rd", longint'(o_fifo_rd), 0);

    // Table: cluster size -> first-beat latency and bursts produced, out_ready held high.
    ready_mode = 1;
    step();
    for (int i = 0; i < 7; i++) begin
      b0 = bursts;
      push_cluster(vecs[i].n_words);
      lat = 0;
      while (!o_out_valid && lat < 100) begin
        step();
        lat++;
      end
      chk($sformatf("latency_n%0d", vecs[i].n_words), lat, vecs[i].exp_lat);
      wait_idle(500);
      chk($sformatf("bursts_n%0d", vecs[i].n_words), bursts - b0, vecs[i].exp_bursts);
    end

    // Backpressure mid-burst.
    push_cluster(12);
    repeat (4) step();
    ready_mode = 0;
    p0 = pops;
    repeat (5) step();
    chk("bp_pops", (pops - p0) <= 1, 1);
    ready_mode = 1;
    wait_idle(500);

    // Refill one cycle before the timeout fires: burst continues.
    begin
      logic [DW-1:0] a, b;
      a = $urandom;
      b = $urandom;
      push_word(a);
      exp_q.push_back('{a, 1'b1, 1'b0});
      repeat (16) step();
      chk("refill_no_out_yet", longint'(o_out_valid), 0);
      push_word(b);
      exp_q.push_back('{b, 1'b0, 1'b1});
      wait_idle(500);
    end

    // Reset with words held in O, P and the FIFO.
    ready_mode = 0;
    step();
    w2 = $urandom;
    push_word($urandom);
    push_word($urandom);
    push_word(w2);
    repeat (4) step();
    chk("pre_rst_busy", longint'(o_busy), 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    bursts = 0;
    chk("midrst_valid", longint'(o_out_valid), 0);
    chk("midrst_first_last", longint'({o_out_first, o_out_last}), 0);
    chk("midrst_data", longint'(o_out_data), 0);
    chk("midrst_busy", longint'(o_busy), 0);
    chk("midrst_burst_cnt", longint'(o_burst_cnt), 0);
    exp_q.push_back('{w2, 1'b1, 1'b1});
    ready_mode = 1;
    wait_idle(500);

    // Four full bursts from reset, then the counter.
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    bursts = 0;
    push_cluster(4 * MB);
    wait_idle(500);
    chk("stats_bursts", bursts, 4);
    chk("stats_burst_cnt", longint'(o_burst_cnt), exp_cnt());

    // Randomized clusters with random backpressure.
    ready_mode = 2;
    for (int c = 0; c < 30; c++) begin
      push_cluster($urandom_range(1, 20));
      wait_idle(2000);
      repeat ($urandom_range(0, 5)) step();
    end
    chk("rand_burst_cnt", longint'(o_burst_cnt), exp_cnt());
    chk("end_exp_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Sits directly downstream of the FIFO; consumes its first-word-fall-through read side (rd/empty/rd_data).
- Repacks the word stream into framed bursts on a valid/ready output stream, with first/last markers.
- A burst closes on max_burst beats, or when the FIFO stays empty for timeout cycles with a word pending.
- Feeds bus masters and packetisers that need explicit burst boundaries.

Parameters:
- data_wd, 32, word width; matches the FIFO data_wd.
- max_burst, 8, maximum beats per burst; must be at least 2.
- bc_wd, 3, beat counter width; 2**bc_wd must be at least max_burst.
- timeout, 16, empty cycles before a pending word is closed as last; must be at least 1.
- to_wd, 5, timeout counter width; must be able to hold timeout.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_rd_data, input, data_wd, FIFO head word; valid whenever fifo_empty is low.
- fifo_rd, output, 1, pop strobe to the FIFO.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, data_wd, beat data.
- out_first, output, 1, first beat of a burst.
- out_last, output, 1, last beat of a burst.
- busy, output, 1, high while a pending or output word is held.
- burst_cnt, output, 16, completed-burst counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; internal pending word (p_valid) cleared, beat index 0, timeout counter 0, start-of-burst flag set.
- Reset mid-burst discards held words; no partial burst is emitted afterwards.
- Two registers: pending P (p_valid, p_data) and output O (out_*). A word waits in P until its last-ness is decided.
- Pop rule: fifo_rd = !fifo_empty && (!p_valid || move). A pop captures fifo_rd_data into P on the same edge.
- fifo_rd is never asserted while fifo_empty is high.
- move = p_valid && o_free && decided, where o_free = !out_valid || out_ready.
- decided is true when any of these holds:
  - beat index == max_burst-1 (last = 1);
  - !fifo_empty (last = 0);
  - timeout counter == timeout (last = 1).
- On move: O takes p_data; out_first = start-of-burst flag; out_last = last.
  - If last: beat index returns to 0 and start flag sets.
  - Otherwise: beat index increments and start flag clears.
- When o_free and no move, out_valid clears.
- Holding rule: out_valid, out_data, out_first and out_last stay stable while out_valid && !out_ready.
- Timeout counter:
  - increments each cycle p_valid && fifo_empty && !decided;
  - saturates at timeout;
  - clears on any pop or move.
- Steady state: one beat per cycle with out_ready held high and the FIFO non-empty. The first beat appears 2 cycles after fifo_empty falls.
- busy = p_valid || out_valid.
- Single-word burst: a lone word times out at beat index 0, so out_first and out_last are both high on that beat.

Optional Feature:
- Macro: FIFO_BURST_DRAIN_STATS_EN.
- Defined: burst_cnt increments on every accepted beat (out_valid && out_ready) with out_last high; it wraps at 16 bits and rst clears it.
- Undefined: burst_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Ten words preloaded, out_ready high: beats 0-7 form burst 1 (first on beat 0, last on beat 7). Beats 8-9 form burst 2, with last on beat 9 only after 16 empty cycles.
- One word pushed into an empty FIFO: single beat with out_first = out_last = 1, out_valid rising 17-18 cycles after the push.
- Backpressure: out_ready low for 5 cycles mid-burst. out_* hold stable, fifo_rd pops at most one word into P, and no data is lost or reordered.
- FIFO refilled at timeout-1 empty cycles: the pending word continues the burst (out_last = 0) and the timer clears.
- rst pulsed with 3 beats held: all outputs 0 next cycle. The next word starts a fresh burst with out_first = 1.
- Stats enabled: 4 bursts of 8 beats accepted, then burst_cnt = 4. Stats disabled: burst_cnt stays 0.
